// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg
// Shared types and helpers for the burst request generator.
//   burst_state_e : generator FSM states (IDLE, BURST)
//   BeatBytes()   : number of bytes moved per beat for a given data width
package mem_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

    // Bytes per data word; this is both the address step between beats and
    // the granularity to which burst base addresses are aligned.
    function automatic int unsigned BeatBytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/mem_burst_req_gen.sv
// mem_burst_req_gen
// Expands one burst descriptor at a time into a stream of per-word memory
// requests with incrementing, word-aligned addresses. Write bursts merge the
// separate write-data stream into the request stream. Bursts can be chained
// with no idle cycle in between.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   desc_addr_i/len_i/we_i       burst descriptor (base address, beats-1, dir)
//   desc_valid_i / desc_ready_o  descriptor handshake
//   wdata_i, wstrb_i             write data and byte strobes
//   wvalid_i / wready_o          write-data handshake
//   req_addr_o, req_we_o         request address and direction
//   req_wdata_o, req_strb_o      request data/strobes (zero on reads)
//   req_last_o                   final beat of the burst
//   req_valid_o / req_ready_i    request handshake
//   busy_o                       a burst is in progress
module mem_burst_req_gen
    import mem_burst_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   desc_addr_i,
    input  logic [LenWidth-1:0]    desc_len_i,
    input  logic                   desc_we_i,
    input  logic                   desc_valid_i,
    output logic                   desc_ready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [AddrWidth-1:0]   req_addr_o,
    output logic                   req_we_o,
    output logic [DataWidth-1:0]   req_wdata_o,
    output logic [DataWidth/8-1:0] req_strb_o,
    output logic                   req_last_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic                   busy_o
);

    localparam int unsigned         BeatB     = BeatBytes(DataWidth);
    localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(BeatB);
    localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(BeatB - 1));

    burst_state_e          state_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [LenWidth-1:0]   rem_q;
    logic                  we_q;

    logic busy;
    logic last_beat;
    logic req_fire;
    logic desc_fire;

    // Handshake decode. Request validity only looks at state and wvalid_i,
    // never at req_ready_i, so the downstream sink can safely make its ready
    // depend on our valid. A new descriptor is taken either when idle or in
    // the very cycle the final beat of the current burst is accepted, which
    // is what lets consecutive bursts run without a bubble.
    always_comb begin
        busy         = (state_q == BURST);
        last_beat    = busy && (rem_q == '0);
        req_valid_o  = busy && (!we_q || wvalid_i);
        req_fire     = req_valid_o && req_ready_i;
        wready_o     = busy && we_q && req_ready_i;
        desc_ready_o = !busy || (req_fire && last_beat);
        desc_fire    = desc_valid_i && desc_ready_o;
    end

    // Request payload. Everything is forced to zero outside a burst so the
    // outputs look identical to their reset values while idle; write data is
    // passed straight through only for write bursts.
    always_comb begin
        busy_o      = busy;
        req_addr_o  = busy ? addr_q : '0;
        req_we_o    = busy && we_q;
        req_last_o  = last_beat;
        req_wdata_o = (busy && we_q) ? wdata_i : '0;
        req_strb_o  = (busy && we_q) ? wstrb_i : '0;
    end

    // Burst FSM with its address and beat counters. A descriptor load wins
    // over the per-beat update: it can only coincide with a request handshake
    // on the final beat, where the old counters are no longer needed. The
    // address add is deliberately left to wrap modulo 2^AddrWidth.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (desc_fire) begin
                        addr_q  <= desc_addr_i & AlignMask;
                        rem_q   <= desc_len_i;
                        we_q    <= desc_we_i;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (desc_fire) begin
                        addr_q  <= desc_addr_i & AlignMask;
                        rem_q   <= desc_len_i;
                        we_q    <= desc_we_i;
                        state_q <= BURST;
                    end else if (req_fire) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                        end else begin
                            addr_q <= addr_q + AddrStep;
                            rem_q  <= rem_q - LenWidth'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_req_gen.sv
// tb_mem_burst_req_gen
// Directed bench for mem_burst_req_gen: a table of per-cycle input/expected
// output records covers read, back-pressured write and back-to-back bursts;
// hand-written sequences cover address wrap, maximum length and reset
// during a burst.
module tb_mem_burst_req_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] desc_addr;
    logic [7:0]  desc_len;
    logic        desc_we;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        req_last;
    logic        req_valid;
    logic        req_ready;
    logic        busy;

    int assert_count = 0;
    int fail_count   = 0;

    typedef struct {
        logic        dv;
        logic [31:0] da;
        logic [7:0]  dl;
        logic        dwe;
        logic        wv;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        rr;
        logic        e_dr;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wd;
        logic [3:0]  e_s;
        logic        e_last;
        logic        e_wr;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mem_burst_req_gen #(
        .AddrWidth(32),
        .DataWidth(32),
        .LenWidth (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .desc_addr_i (desc_addr),
        .desc_len_i  (desc_len),
        .desc_we_i   (desc_we),
        .desc_valid_i(desc_valid),
        .desc_ready_o(desc_ready),
        .wdata_i     (wdata),
        .wstrb_i     (wstrb),
        .wvalid_i    (wvalid),
        .wready_o    (wready),
        .req_addr_o  (req_addr),
        .req_we_o    (req_we),
        .req_wdata_o (req_wdata),
        .req_strb_o  (req_strb),
        .req_last_o  (req_last),
        .req_valid_o (req_valid),
        .req_ready_i (req_ready),
        .busy_o      (busy)
    );

    function automatic vec_t mk(
        input logic dv, input logic [31:0] da, input logic [7:0] dl, input logic dwe,
        input logic wv, input logic [31:0] wd, input logic [3:0] ws, input logic rr,
        input logic e_dr, input logic e_rv, input logic [31:0] e_addr, input logic e_we,
        input logic [31:0] e_wd, input logic [3:0] e_s, input logic e_last,
        input logic e_wr, input logic e_busy);
        vec_t v;
        v.dv = dv; v.da = da; v.dl = dl; v.dwe = dwe;
        v.wv = wv; v.wd = wd; v.ws = ws; v.rr = rr;
        v.e_dr = e_dr; v.e_rv = e_rv; v.e_addr = e_addr; v.e_we = e_we;
        v.e_wd = e_wd; v.e_s = e_s; v.e_last = e_last; v.e_wr = e_wr; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the rising edge and lets the
    // combinational outputs settle before anything is sampled.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        desc_valid = v.dv;
        desc_addr  = v.da;
        desc_len   = v.dl;
        desc_we    = v.dwe;
        wvalid     = v.wv;
        wdata      = v.wd;
        wstrb      = v.ws;
        req_ready  = v.rr;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkVal({tag, ".desc_ready"}, 64'(desc_ready), 64'(v.e_dr));
        checkVal({tag, ".req_valid"},  64'(req_valid),  64'(v.e_rv));
        checkVal({tag, ".req_addr"},   64'(req_addr),   64'(v.e_addr));
        checkVal({tag, ".req_we"},     64'(req_we),     64'(v.e_we));
        checkVal({tag, ".req_wdata"},  64'(req_wdata),  64'(v.e_wd));
        checkVal({tag, ".req_strb"},   64'(req_strb),   64'(v.e_s));
        checkVal({tag, ".req_last"},   64'(req_last),   64'(v.e_last));
        checkVal({tag, ".wready"},     64'(wready),     64'(v.e_wr));
        checkVal({tag, ".busy"},       64'(busy),       64'(v.e_busy));
    endtask

    // Read-only cycle with write stream idle; used by the hand-written parts.
    task automatic driveRead(input logic dv, input logic [31:0] da, input logic [7:0] dl,
                             input logic rr);
        applyStimulus(mk(dv, da, dl, 1'b0, 1'b0, 32'h0, 4'h0, rr,
                         1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        // Read burst 0x1003 len 3: aligned to 0x1000, four beats.
        tbl.push_back(mk(1, 32'h1003, 8'd3, 0, 0, 32'h0, 4'h0, 1,  1, 0, 32'h0,    0, 32'h0, 4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0, 4'h0, 1,  0, 1, 32'h1000, 0, 32'h0, 4'h0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0, 4'h0, 1,  0, 1, 32'h1004, 0, 32'h0, 4'h0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0, 4'h0, 1,  0, 1, 32'h1008, 0, 32'h0, 4'h0, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0, 4'h0, 1,  1, 1, 32'h100C, 0, 32'h0, 4'h0, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0, 4'h0, 1,  1, 0, 32'h0,    0, 32'h0, 4'h0, 0, 0, 0));
        // Write burst len 1 with a wvalid gap and two stalled cycles.
        tbl.push_back(mk(1, 32'h2000, 8'd1, 1, 0, 32'h0,        4'h0, 1,  1, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'hDEAD0000, 4'h0, 1,  0, 0, 32'h2000, 1, 32'hDEAD0000, 4'h0, 0, 1, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h11112222, 4'h3, 0,  0, 1, 32'h2000, 1, 32'h11112222, 4'h3, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h11112222, 4'h3, 0,  0, 1, 32'h2000, 1, 32'h11112222, 4'h3, 0, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h11112222, 4'h3, 1,  0, 1, 32'h2000, 1, 32'h11112222, 4'h3, 0, 1, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h33334444, 4'hC, 1,  1, 1, 32'h2004, 1, 32'h33334444, 4'hC, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h99990000, 4'hF, 1,  1, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0));
        // Back-to-back: read len 1, then write len 0 accepted on its last beat.
        tbl.push_back(mk(1, 32'h3000, 8'd1, 0, 0, 32'h0,        4'h0, 1,  1, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0,        4'h0, 1,  0, 1, 32'h3000, 0, 32'h0,        4'h0, 0, 0, 1));
        tbl.push_back(mk(1, 32'h4008, 8'd0, 1, 1, 32'h55556666, 4'hF, 1,  1, 1, 32'h3004, 0, 32'h0,        4'h0, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 1, 32'h77778888, 4'h5, 1,  1, 1, 32'h4008, 1, 32'h77778888, 4'h5, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0,    8'd0, 0, 0, 32'h0,        4'h0, 1,  1, 0, 32'h0,    0, 32'h0,        4'h0, 0, 0, 0));

        rst        = 1'b1;
        desc_valid = 1'b0;
        desc_addr  = '0;
        desc_len   = '0;
        desc_we    = 1'b0;
        wvalid     = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        req_ready  = 1'b0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #2;
        checkOutput(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 32'h0, 4'h0, 0, 0, 0), "reset");
        rst = 1'b0;

        // Table-driven cycles.
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("row%0d", i));
        end

        // Address wrap: 0xFFFF_FFF8 len 2.
        driveRead(1'b1, 32'hFFFF_FFF8, 8'd2, 1'b1);
        checkVal("wrap.desc_ready", 64'(desc_ready), 64'd1);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("wrap.addr0", 64'(req_addr), 64'hFFFF_FFF8);
        checkVal("wrap.last0", 64'(req_last), 64'd0);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("wrap.addr1", 64'(req_addr), 64'hFFFF_FFFC);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("wrap.addr2", 64'(req_addr), 64'h0);
        checkVal("wrap.last2", 64'(req_last), 64'd1);
        checkVal("wrap.valid2", 64'(req_valid), 64'd1);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("wrap.busy_after", 64'(busy), 64'd0);

        // Maximum length: 256 beats from 0x8000, last at 0x83FC.
        driveRead(1'b1, 32'h8000, 8'd255, 1'b1);
        for (int i = 0; i < 256; i++) begin
            driveRead(1'b0, 32'h0, 8'd0, 1'b1);
            checkVal($sformatf("max.addr%0d", i), 64'(req_addr), 64'(32'h8000 + 32'(4 * i)));
            checkVal($sformatf("max.last%0d", i), 64'(req_last), 64'(i == 255));
            checkVal($sformatf("max.valid%0d", i), 64'(req_valid), 64'd1);
        end
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("max.busy_after", 64'(busy), 64'd0);
        checkVal("max.valid_after", 64'(req_valid), 64'd0);

        // Reset during beat 3 of a len 7 burst.
        driveRead(1'b1, 32'h9000, 8'd7, 1'b1);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("rstmid.addr0", 64'(req_addr), 64'h9000);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("rstmid.addr1", 64'(req_addr), 64'h9004);
        driveRead(1'b0, 32'h0, 8'd0, 1'b0);
        checkVal("rstmid.valid_before", 64'(req_valid), 64'd1);
        rst = 1'b1;
        #1;
        checkVal("rstmid.valid_async", 64'(req_valid), 64'd0);
        checkVal("rstmid.busy_async", 64'(busy), 64'd0);
        checkVal("rstmid.addr_async", 64'(req_addr), 64'h0);
        checkVal("rstmid.desc_ready", 64'(desc_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveRead(1'b1, 32'hA004, 8'd0, 1'b1);
        checkVal("rstmid.new_desc_ready", 64'(desc_ready), 64'd1);
        driveRead(1'b0, 32'h0, 8'd0, 1'b1);
        checkVal("rstmid.new_addr", 64'(req_addr), 64'hA004);
        checkVal("rstmid.new_last", 64'(req_last), 64'd1);
        checkVal("rstmid.new_valid", 64'(req_valid), 64'd1);
        driveRead(1'b0, 32'h0, 8'd0, 1'b0);
        checkVal("rstmid.idle_after", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
